// File: rtl/demux_1to3_reg_if.sv
// Handshake bundle for the registered 1-to-3 distributor: one input channel, three output channels.
interface demux_1to3_reg_if #(
  parameter int unsigned DATA_W = 6
);
  logic [DATA_W-1:0] in_data;
  logic [1:0]        in_sel;
  logic              in_valid;
  logic              in_ready;

  logic [DATA_W-1:0] out_a_data;
  logic              out_a_valid;
  logic              out_a_ready;
  logic [DATA_W-1:0] out_b_data;
  logic              out_b_valid;
  logic              out_b_ready;
  logic [DATA_W-1:0] out_c_data;
  logic              out_c_valid;
  logic              out_c_ready;

  // Producer/consumer side: drives the input word and the consumer readies
  modport master (
    output in_data, in_sel, in_valid,
    output out_a_ready, out_b_ready, out_c_ready,
    input  in_ready,
    input  out_a_data, out_a_valid,
    input  out_b_data, out_b_valid,
    input  out_c_data, out_c_valid
  );

  // Distributor side
  modport slave (
    input  in_data, in_sel, in_valid,
    input  out_a_ready, out_b_ready, out_c_ready,
    output in_ready,
    output out_a_data, out_a_valid,
    output out_b_data, out_b_valid,
    output out_c_data, out_c_valid
  );
endinterface

// File: rtl/demux_1to3_reg.sv
// Registered 1-to-3 distributor: routes each accepted word to one of three
// one-entry holding registers selected by in_sel (11 = drop).
// Optional build macro DEMUX3_DROP_CNT_EN adds a saturating 8-bit drop_count.
module demux_1to3_reg #(
  parameter int unsigned DATA_W = 6
) (
  input  logic               clk,
  input  logic               rst,
  demux_1to3_reg_if.slave    bus
`ifdef DEMUX3_DROP_CNT_EN
  ,
  output logic [7:0]         drop_count
`endif
);

  localparam int unsigned NUM_CH = 3;
  localparam int unsigned SEL_W  = 2;
`ifdef DEMUX3_DROP_CNT_EN
  localparam int unsigned CNT_W  = 8;
`endif

  typedef enum logic {
    EMPTY = 1'b0,
    FULL  = 1'b1
  } ch_state_t;

  ch_state_t         state_q [NUM_CH];
  ch_state_t         state_d [NUM_CH];
  logic [DATA_W-1:0] data_q  [NUM_CH];
  logic [NUM_CH-1:0] out_rdy;
  logic [NUM_CH-1:0] out_vld;
  logic [NUM_CH-1:0] route;
  logic              in_ready_c;
  logic              accept;

  assign out_rdy = {bus.out_c_ready, bus.out_b_ready, bus.out_a_ready};
  assign accept  = bus.in_valid & in_ready_c;

  // Valid bits are the channel state registers themselves
  always_comb begin
    for (int i = 0; i < NUM_CH; i++) begin
      out_vld[i] = (state_q[i] == FULL);
    end
  end

  // Input ready: selected channel empty or draining this cycle; drop selector always ready
  always_comb begin
    in_ready_c = 1'b1;
    case (bus.in_sel)
      2'd0:    in_ready_c = !out_vld[0] | out_rdy[0];
      2'd1:    in_ready_c = !out_vld[1] | out_rdy[1];
      2'd2:    in_ready_c = !out_vld[2] | out_rdy[2];
      default: in_ready_c = 1'b1;
    endcase
  end

  assign bus.in_ready = in_ready_c;

  // Per-channel next state: refill wins over drain, so drain+refill stays FULL
  always_comb begin
    for (int i = 0; i < NUM_CH; i++) begin
      state_d[i] = state_q[i];
      route[i]   = accept && (bus.in_sel == SEL_W'(i));
      if (route[i]) begin
        state_d[i] = FULL;
      end else if (out_vld[i] && out_rdy[i]) begin
        state_d[i] = EMPTY;
      end
    end
  end

  // Channel state registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NUM_CH; i++) begin
        state_q[i] <= EMPTY;
      end
    end else begin
      for (int i = 0; i < NUM_CH; i++) begin
        state_q[i] <= state_d[i];
      end
    end
  end

  // Holding data: loads only on a routed accept, keeps its value after a drain
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NUM_CH; i++) begin
        data_q[i] <= '0;
      end
    end else begin
      for (int i = 0; i < NUM_CH; i++) begin
        if (route[i]) begin
          data_q[i] <= bus.in_data;
        end
      end
    end
  end

  assign bus.out_a_data  = data_q[0];
  assign bus.out_b_data  = data_q[1];
  assign bus.out_c_data  = data_q[2];
  assign bus.out_a_valid = out_vld[0];
  assign bus.out_b_valid = out_vld[1];
  assign bus.out_c_valid = out_vld[2];

`ifdef DEMUX3_DROP_CNT_EN
  logic drop;
  assign drop = accept && (bus.in_sel == SEL_W'(3));

  // Saturating count of accepted-and-dropped words
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      drop_count <= '0;
    end else if (drop && (drop_count != {CNT_W{1'b1}})) begin
      drop_count <= drop_count + CNT_W'(1);
    end
  end
`endif

endmodule

// File: doc/demux_1to3_reg.md
Name: demux_1to3_reg

Overview:
- Registered 1-to-3 distributor; the opposite direction of the datapath 3-to-1 operand selector.
- Accepts one word plus a 2-bit destination selector on a valid/ready input channel.
- Routes each word to exactly one of three output channels, each with a one-entry holding register and its own valid/ready handshake.
- Sits between a result producer and up to three consumers (e.g. writeback, forwarding, debug tap).

Parameters:
- DATA_W, 6, width of data words on every channel (the datapath target is 32; 6 is the current build width).

Ports:
- clk  input  1  single clock, rising-edge.
- rst  input  1  asynchronous, active-high reset.
- in_data  input  DATA_W  word to route.
- in_sel  input  2  destination selector: 00 = a, 01 = b, 10 = c, 11 = invalid.
- in_valid  input  1  input word/selector valid.
- in_ready  output  1  block accepts the input this cycle.
- out_a_data / out_b_data / out_c_data  output  DATA_W each  registered data per channel.
- out_a_valid / out_b_valid / out_c_valid  output  1 each  channel holds a word.
- out_a_ready / out_b_ready / out_c_ready  input  1 each  consumer takes the word.
- drop_count  output  8  only with DEMUX3_DROP_CNT_EN; count of dropped sel = 11 words.

Behaviour:
- Reset (asynchronous, rst = 1):
  - All out_x_valid = 0 and all out_x_data = 0, immediately.
  - drop_count = 0.
  - Reset mid-transfer discards held words without emitting them.
  - in_ready is combinational and may be 1 during reset, but nothing is accepted while rst = 1.
- Per-channel state:
  - Each channel is an EMPTY/FULL holding register (valid bit = FULL).
  - drain_x = out_x_valid & out_x_ready.
- in_ready (combinational, from in_sel and channel state):
  - sel 00/01/10: in_ready = !out_x_valid | out_x_ready for the selected channel.
  - sel 11: in_ready = 1.
- Accept: in_valid & in_ready at a rising edge.
- Latency: a word accepted at edge N appears on out_x_data with out_x_valid = 1 after edge N.
- Throughput: one word per cycle while the selected consumer keeps ready = 1. Simultaneous drain and refill of the same channel at one edge leaves valid = 1 with the new data.
- Channel update at each edge:
  - Accepted and routed to x: data_x <= in_data, valid_x <= 1.
  - Else if drain_x: valid_x <= 0; data_x holds its last value (not cleared).
  - Else: hold.
- Stability: while out_x_valid & !out_x_ready, out_x_data and out_x_valid do not change.
- Independence: a stalled channel never blocks traffic to other channels. Input blocks only when its selected channel is FULL and not draining.
- Ordering: per-channel order is preserved. No cross-channel ordering guarantee beyond acceptance order.
- Invalid selector (sel = 11): the word is accepted and dropped. No channel changes.
- No combinational path from in_data to any output. Output ready inputs feed only in_ready.

Optional Feature:
- Macro DEMUX3_DROP_CNT_EN.
- Defined:
  - drop_count port exists.
  - 8-bit counter increments on each accepted sel = 11 word.
  - Saturates at 255; no wrap.
  - Cleared only by rst.
- Undefined:
  - Port and counter are absent.
  - sel = 11 words are still accepted and silently dropped.

Test Plan:
- Reset then idle:
  - Stimulus: rst = 1 for 2 cycles with in_valid = 1, in_sel = 00, in_data = 0x2A.
  - Required: all out_x_valid = 0 and all out_x_data = 0 throughout; no word emitted after release until the next accept.
- Routing:
  - Stimulus: in_data = 0x15 sel 00, then 0x2A sel 01, then 0x3F sel 10 on consecutive cycles, all out_x_ready = 1.
  - Required: each word appears one cycle after its accept on a, b, c respectively, valid for exactly 1 cycle.
- Backpressure:
  - Stimulus: out_a_ready = 0; send 0x01 then 0x02 to a.
  - Required:
    - 0x01 held on out_a with valid = 1 and in_ready = 0 for sel 00.
    - Raising out_a_ready for one cycle accepts 0x02 in that same cycle; out_a_data = 0x02 next cycle.
- Non-blocking:
  - Stimulus: a stalled full; send 0x07 to b.
  - Required: in_ready = 1; out_b_data = 0x07 next cycle; out_a unchanged.
- Drop (with DEMUX3_DROP_CNT_EN):
  - Stimulus: 300 consecutive sel = 11 words.
  - Required: in_ready = 1 throughout; no out_x_valid rises; drop_count ends at 255.
  - Then: rst pulse mid-stream gives drop_count = 0 immediately.
- Reset mid-transfer:
  - Stimulus: out_c_valid = 1 holding 0x33 with out_c_ready = 0; assert rst between clock edges.
  - Required: out_c_valid = 0 and out_c_data = 0 before the next edge.
